// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes and the error-responder state type.
package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // state | meaning
  // IDLE  | no pending error, waiting for the decoder to reject an AR
  // DRAIN | error captured, waiting for routed reads to finish
  // SEND  | driving DECERR beats until the last one handshakes
  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SEND
  } err_state_t;

endpackage

// File: rtl/axi_outstanding_counter.sv
// Saturating count of routed transactions still in flight at one target port.
// Shared by the read- and write-side error responders.
module axi_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic incr,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] r_count;

  // Count up on incr, down on dec, hold when both or neither; clamp at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (incr && !dec && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !incr && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign full    = (r_count == CNT_MAX);
  assign nonzero = (r_count != '0);

  a_no_incr_when_full : assert property (@(posedge clk) disable iff (rst)
    !(incr && !dec && full));
  a_no_dec_when_empty : assert property (@(posedge clk) disable iff (rst)
    !(dec && !incr && !nonzero));

endmodule

// File: rtl/axi_read_error_responder.sv
// Read-side error responder: tracks routed reads for the AR decoder and, for an
// unmapped AR, emits a full DECERR burst once the legitimate reads have drained.
module axi_read_error_responder
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_WIDTH    = 6,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      incr_req_i,
  input  logic                      r_mon_valid_i,
  input  logic                      r_mon_ready_i,
  input  logic                      r_mon_last_i,
  output logic                      full_counter_o,
  output logic                      outstanding_trans_o,
  input  logic                      sample_ardata_info_i,
  input  logic [AXI_ID_WIDTH-1:0]   arid_i,
  input  logic [7:0]                arlen_i,
  input  logic [AXI_USER_WIDTH-1:0] aruser_i,
  output logic                      error_gnt_o,
  output logic [AXI_ID_WIDTH-1:0]   rid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rlast_o,
  output logic [AXI_USER_WIDTH-1:0] ruser_o,
  output logic                      rvalid_o,
  input  logic                      rready_i
);

  err_state_t                r_state;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [7:0]                r_len;
  logic [7:0]                r_beat_cnt;
  logic [AXI_USER_WIDTH-1:0] r_user;

  logic w_dec;
  logic w_hs;
  logic w_final;

  // A routed read retires only on its last monitored R beat.
  assign w_dec = r_mon_valid_i & r_mon_ready_i & r_mon_last_i;

  axi_outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .incr   (incr_req_i),
    .dec    (w_dec),
    .full   (full_counter_o),
    .nonzero(outstanding_trans_o)
  );

  assign w_hs    = rvalid_o & rready_i;
  assign w_final = (r_beat_cnt == r_len);

  // Capture the rejected AR, wait for the port to go quiet, then stream the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_user     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_ardata_info_i) begin
            r_id       <= arid_i;
            r_len      <= arlen_i;
            r_user     <= aruser_i;
            r_beat_cnt <= '0;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!outstanding_trans_o) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_final) begin
              r_state <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // rvalid decodes straight from the state register so reset drops it at once.
  assign rvalid_o    = (r_state == SEND);
  assign rlast_o     = rvalid_o & w_final;
  assign error_gnt_o = w_hs & w_final;
  assign rid_o       = r_id;
  assign ruser_o     = r_user;
  assign rresp_o     = RESP_DECERR;
  assign rdata_o     = '0;

  a_sample_only_in_idle : assert property (@(posedge clk) disable iff (rst)
    sample_ardata_info_i |-> (r_state == IDLE));

endmodule

// File: tb/tb_axi_read_error_responder.sv
// Self-checking bench for axi_read_error_responder (default parameters).
module tb_axi_read_error_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        incr_req_i, r_mon_valid_i, r_mon_ready_i, r_mon_last_i;
  logic        full_counter_o, outstanding_trans_o;
  logic        sample_ardata_info_i;
  logic [5:0]  arid_i;
  logic [7:0]  arlen_i;
  logic [5:0]  aruser_i;
  logic        error_gnt_o;
  logic [5:0]  rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic [5:0]  ruser_o;
  logic        rvalid_o;
  logic        rready_i;

  axi_read_error_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .incr_req_i          (incr_req_i),
    .r_mon_valid_i       (r_mon_valid_i),
    .r_mon_ready_i       (r_mon_ready_i),
    .r_mon_last_i        (r_mon_last_i),
    .full_counter_o      (full_counter_o),
    .outstanding_trans_o (outstanding_trans_o),
    .sample_ardata_info_i(sample_ardata_info_i),
    .arid_i              (arid_i),
    .arlen_i             (arlen_i),
    .aruser_i            (aruser_i),
    .error_gnt_o         (error_gnt_o),
    .rid_o               (rid_o),
    .rdata_o             (rdata_o),
    .rresp_o             (rresp_o),
    .rlast_o             (rlast_o),
    .ruser_o             (ruser_o),
    .rvalid_o            (rvalid_o),
    .rready_i            (rready_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;   // reference count of in-flight routed reads
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: fold this cycle's inputs into the reference count, then
  // return 1 time unit after the edge with all pulse inputs cleared.
  task automatic tick();
    if (rst) m_cnt = 0;
    else begin
      if (incr_req_i && !(r_mon_valid_i && r_mon_ready_i && r_mon_last_i)) m_cnt++;
      else if (!incr_req_i && (r_mon_valid_i && r_mon_ready_i && r_mon_last_i)) m_cnt--;
      if (m_cnt > 8) m_cnt = 8;
      if (m_cnt < 0) m_cnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    incr_req_i = 0; sample_ardata_info_i = 0;
    r_mon_valid_i = 0; r_mon_ready_i = 0; r_mon_last_i = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_counter(input string tag);
    chk({tag, "_full"}, full_counter_o, m_cnt == 8);
    chk({tag, "_outst"}, outstanding_trans_o, m_cnt != 0);
  endtask

  // One error transaction: k routed reads outstanding, then an unmapped AR.
  // pat gives rready for successive cycles once the burst is expected to start.
  task automatic run_error(input string tag, input logic [5:0] id, input logic [7:0] len,
                           input logic [5:0] user, input int k, input logic [31:0] pat);
    int zero_cyc, beats, pi, budget;
    bit exp_v, exp_last;
    for (int i = 0; i < k; i++) begin
      incr_req_i = 1;
      tick();
    end
    settle();
    chk_counter({tag, "_pre"});
    arid_i = id; arlen_i = len; aruser_i = user;
    sample_ardata_info_i = 1;
    rready_i = 1'($urandom_range(0, 1));
    settle();
    chk({tag, "_rvalid_at_sample"}, rvalid_o, 0);
    tick();
    // captured values must not track later changes on the AR inputs
    arid_i = 6'($urandom); arlen_i = 8'($urandom); aruser_i = 6'($urandom);
    zero_cyc = -1; beats = 0; pi = 0; budget = 0;
    while (beats <= int'(len) && budget < 300) begin
      budget++;
      if (zero_cyc < 0 && m_cnt == 0) zero_cyc = cyc;
      exp_v = (zero_cyc >= 0) && (cyc > zero_cyc);
      if (!exp_v && m_cnt > 0 && $urandom_range(0, 2) != 0) begin
        r_mon_valid_i = 1; r_mon_ready_i = 1;
        r_mon_last_i  = 1'($urandom_range(0, 1));
      end
      rready_i = exp_v ? ((pi < 32) ? pat[pi] : 1'b1) : 1'($urandom_range(0, 1));
      exp_last = exp_v && (beats == int'(len));
      settle();
      chk({tag, "_rvalid"}, rvalid_o, exp_v);
      chk({tag, "_rlast"}, rlast_o, exp_last);
      chk({tag, "_gnt"}, error_gnt_o, exp_last && rready_i);
      if (exp_v) begin
        chk({tag, "_rid"}, rid_o, id);
        chk({tag, "_ruser"}, ruser_o, user);
        chk({tag, "_rresp"}, rresp_o, 2'b11);
        chk({tag, "_rdata"}, rdata_o, 64'h0);
        pi++;
        if (rready_i) beats++;
      end
      tick();
    end
    chk({tag, "_no_timeout"}, budget < 300, 1);
    rready_i = 1;
    settle();
    chk({tag, "_rvalid_after"}, rvalid_o, 0);
    chk({tag, "_gnt_after"}, error_gnt_o, 0);
    chk_counter({tag, "_post"});
    tick();
  endtask

  initial begin
    rst = 1;
    incr_req_i = 0; r_mon_valid_i = 0; r_mon_ready_i = 0; r_mon_last_i = 0;
    sample_ardata_info_i = 0; arid_i = 0; arlen_i = 0; aruser_i = 0; rready_i = 0;
    repeat (3) tick();
    rst = 0;
    tick();

    // reset state
    settle();
    chk_counter("reset");
    chk("reset_rvalid", rvalid_o, 0);
    chk("reset_rlast", rlast_o, 0);
    chk("reset_gnt", error_gnt_o, 0);
    chk("reset_rresp", rresp_o, 2'b11);

    // fill to MAX_OUTSTANDING, then simultaneous incr+dec, then drain
    for (int i = 0; i < 8; i++) begin
      incr_req_i = 1;
      tick();
      settle();
      chk_counter("fill");
    end
    incr_req_i = 1; r_mon_valid_i = 1; r_mon_ready_i = 1; r_mon_last_i = 1;
    tick();
    settle();
    chk_counter("incr_dec_full");
    r_mon_valid_i = 1; r_mon_ready_i = 1; r_mon_last_i = 0;  // non-last beat: no retire
    tick();
    settle();
    chk_counter("nonlast_beat");
    for (int i = 0; i < 8; i++) begin
      r_mon_valid_i = 1; r_mon_ready_i = 1; r_mon_last_i = 1;
      tick();
      settle();
      chk_counter("drain");
    end

    // directed error bursts
    run_error("single", 6'h15, 8'd0, 6'h2A, 0, 32'hFFFF_FFFF);
    run_error("len3_k2", 6'h07, 8'd3, 6'h11, 2, 32'hFFFF_FFFF);
    run_error("stall", 6'h3C, 8'd2, 6'h05, 0, 32'hFFFF_FFF9);

    // reset during the 2nd beat of a 4-beat burst
    arid_i = 6'h12; arlen_i = 8'd3; aruser_i = 6'h21;
    sample_ardata_info_i = 1; rready_i = 1;
    tick();
    tick();
    settle();
    chk("rstmid_beat1", rvalid_o, 1);
    tick();
    rready_i = 0;
    settle();
    chk("rstmid_beat2", rvalid_o, 1);
    rst = 1;
    #1;
    chk("rstmid_async_rvalid", rvalid_o, 0);
    chk("rstmid_async_gnt", error_gnt_o, 0);
    tick();
    rst = 0;
    rready_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rstmid_after_rvalid", rvalid_o, 0);
      chk("rstmid_after_gnt", error_gnt_o, 0);
      chk_counter("rstmid_after");
      tick();
    end

    // reset clears a nonzero counter
    for (int i = 0; i < 3; i++) begin
      incr_req_i = 1;
      tick();
    end
    settle();
    chk_counter("rstcnt_pre");
    rst = 1;
    #1;
    chk("rstcnt_async", outstanding_trans_o, 0);
    tick();
    rst = 0;
    tick();
    settle();
    chk_counter("rstcnt_post");

    // randomized error transactions
    for (int n = 0; n < 20; n++) begin
      run_error("rand", 6'($urandom), 8'($urandom_range(0, 7)), 6'($urandom),
                int'($urandom_range(0, 3)), $urandom | 32'h8888_8888);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_read_error_responder.md
# axi_read_error_responder

Read-side companion of the AR address decoder in the AXI node. It tracks outstanding read transactions per target port and drives the decoder's `full_counter_i` and `outstanding_trans_i` inputs. When the decoder rejects an unmapped address, the block captures the AR info, waits until all legitimate reads have drained, then emits a complete DECERR R burst. On the last beat it grants the error back to the decoder. One instance sits per target (master-side) port, beside the R response mux.

## Interface
Parameters:
- AXI_ID_WIDTH, 6: ARID/RID width
- AXI_DATA_WIDTH, 64: RDATA width
- AXI_USER_WIDTH, 6: ARUSER/RUSER width
- MAX_OUTSTANDING, 8: maximum in-flight routed reads; counter width CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  input  1  clock; everything is rising-edge
- rst  input  1  reset, asynchronous and active-high
- incr_req_i  input  1  one pulse per accepted routed AR (from the decoder)
- r_mon_valid_i, r_mon_ready_i, r_mon_last_i  input  1 each  monitored legitimate R handshake at this target port
- full_counter_o  output  1  outstanding count == MAX_OUTSTANDING
- outstanding_trans_o  output  1  outstanding count != 0
- sample_ardata_info_i  input  1  decoder has accepted an unmapped AR; capture the AR fields
- arid_i  input  AXI_ID_WIDTH  captured ID
- arlen_i  input  8  captured burst length
- aruser_i  input  AXI_USER_WIDTH  captured user
- error_gnt_o  output  1  error burst completed (to the decoder's error_gnt_i)
- rid_o  output  AXI_ID_WIDTH  response ID
- rdata_o  output  AXI_DATA_WIDTH  response data
- rresp_o  output  2  response code
- rlast_o  output  1  last beat of the burst
- ruser_o  output  AXI_USER_WIDTH  response user
- rvalid_o  output  1  error beat valid
- rready_i  input  1  master ready for the error beat

## Operation
- Outstanding counter:
  - Decrement (dec) = r_mon_valid_i & r_mon_ready_i & r_mon_last_i.
  - incr only: +1. dec only: −1. Both in the same cycle: unchanged.
  - incr while full and dec while zero are illegal (assertions). The counter saturates and never wraps.
- Error FSM, states IDLE, DRAIN, SEND:
  - IDLE: when sample_ardata_info_i=1, register arid/arlen/aruser, clear beat_cnt, go to DRAIN.
  - DRAIN: when outstanding_trans_o=0 (evaluated every cycle, including the first), go to SEND.
  - SEND: rvalid_o=1. Each rvalid_o&rready_i increments beat_cnt.
    - Final beat is the handshake with beat_cnt==len. On it, error_gnt_o=1 (combinational, same cycle) and go to IDLE.
- Output values:
  - rresp_o = 2'b11 (DECERR), rdata_o = '0.
  - rid_o and ruser_o are the captured values.
  - rlast_o = rvalid_o & (beat_cnt==len).
- sample_ardata_info_i outside IDLE is ignored and flagged by an assertion. The decoder stalls AR while in ERROR, so this cannot occur legally.
- rvalid_o stays high until the handshake; the payload is stable while rvalid_o=1 and rready_i=0.
- The block only drives error beats. The R mux selects this source while rvalid_o=1. DRAIN guarantees no legitimate R burst is in flight.

## Timing
- Reset values:
  - state=IDLE, count=0, beat_cnt=0.
  - rvalid_o=0, rlast_o=0, error_gnt_o=0.
  - full_counter_o=0, outstanding_trans_o=0.
  - rid_o, ruser_o, rresp_o and rdata_o hold their reset/idle values; rresp_o is constant DECERR.
- Reset asserted mid-burst: rvalid_o drops immediately (asynchronous), the pending error is discarded, and the counter clears.
- Counter outputs are registered: an event in cycle t is visible at t+1.
- Error latency with no outstanding reads and rready_i=1:
  - sample in cycle 0, DRAIN in cycle 1, first beat in cycle 2.
  - Last beat and error_gnt_o in cycle 2+arlen.
- With outstanding reads, SEND begins the cycle after outstanding_trans_o falls.
- error_gnt_o is exactly one cycle wide per error burst.

## Structure
- Shared package axi_node_pkg holds:
  - RESP_OKAY/RESP_EXOKAY/RESP_SLVERR/RESP_DECERR localparams.
  - err_state_t enum {IDLE, DRAIN, SEND}.
- Sub-module axi_outstanding_counter (parameters MAX_OUTSTANDING; ports incr, dec, full, nonzero) holds the saturating counter. It is reused by the write-side responder.

## Test plan
- Reset release with no traffic → full_counter_o=0, outstanding_trans_o=0, rvalid_o=0.
- Eight incr_req_i pulses (MAX_OUTSTANDING=8), no dec → full_counter_o=1 one cycle after the 8th pulse. Then simultaneous incr+dec → count stays 8.
- arlen_i=0, arid_i=6'h15, count=0, rready_i=1 → single beat in cycle 2 with rid_o=6'h15, rresp_o=2'b11, rlast_o=1, error_gnt_o=1 in the same cycle.
- arlen_i=3, count=2 → rvalid_o stays low until both monitored last beats complete. Then 4 beats, rlast_o only on the 4th.
- arlen_i=2 with rready_i toggling 1,0,0,1,1 → rid_o, rresp_o and rlast_o stable while stalled. error_gnt_o exactly once, on the 3rd handshake.
- rst asserted during the 2nd beat of a 4-beat burst → rvalid_o=0 immediately. After release, state IDLE, count 0, no error_gnt_o.
